axis_pattern_gen: RTL and testbench
===================================

AXIS_PATTERN_GEN -- requirements
Module: axis_pattern_gen

Interface
REQ-001 SHALL have parameter TBYTE_NUM, default 16, bytes per beat (1..64).
REQ-002 SHALL have parameter ID_W, default 5, width of m_axis_tid.
REQ-003 SHALL have parameter DEST_W, default 5, width of m_axis_tdest.
REQ-004 SHALL have parameter CNT_W, default 32, width of all length/gap/count fields.
REQ-005 SHALL have port clk  in  1  sole clock, all logic rising-edge; one clock, reset is asynchronous and active-high.
REQ-006 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports pkt_dest in DEST_W; pkt_gap in CNT_W (idle cycles between packets); pkt_num in CNT_W (packets per run); pkt_bytes in CNT_W (bytes per packet).
REQ-008 SHALL have ports mode in 2 (0 fixed, 1 increment, 2 LFSR); start_from in TBYTE_NUM*8 (seed); inc in TBYTE_NUM*8 (increment step).
REQ-009 SHALL have ports stream_start in 1; stream_abort in 1; stream_busy out 1; stream_done out 1 (one-cycle pulse); pkt_sent out CNT_W (packets completed this run).
REQ-010 SHALL have AXI-Stream master ports m_axis_tvalid, m_axis_tready(in), m_axis_tdata TBYTE_NUM*8, m_axis_tkeep TBYTE_NUM, m_axis_tlast, m_axis_tid ID_W, m_axis_tdest DEST_W.

Function
REQ-011 SHALL implement states IDLE, LOAD, PKT, GAP, DONE; beat accepted = tvalid & tready.
REQ-012 IDLE->LOAD on stream_start; stream_start SHALL be ignored in all other states.
REQ-013 LOAD (one cycle) SHALL latch all config inputs; later input changes SHALL not affect the run.
REQ-014 LOAD->DONE if latched pkt_num==0 or pkt_bytes==0; else LOAD->PKT; tvalid first high 2 cycles after start sampled.
REQ-015 Beats per packet SHALL be ceil(pkt_bytes/TBYTE_NUM); tlast SHALL be high exactly on final beat.
REQ-016 tkeep SHALL be all-ones except final beat, where low (pkt_bytes mod TBYTE_NUM) bits set (all-ones if remainder 0).
REQ-017 While tvalid=1 and tready=0, tdata/tkeep/tlast/tid/tdest SHALL hold stable; tvalid SHALL not drop until accepted.
REQ-018 Mode 0: tdata=start_from every beat. Mode 1: first beat of each packet =start_from, each accepted beat adds inc, modulo 2^(TBYTE_NUM*8). Mode 3 SHALL behave as mode 0.
REQ-019 Mode 2: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seeded from start_from[31:0] (zero seed replaced by 1) once per run, stepped once per accepted beat, continuing across packets; tdata = state replicated across all 32-bit lanes (truncated when TBYTE_NUM*8 not multiple of 32).
REQ-020 Final accepted beat: PKT->GAP if pkt_gap>0, else straight to next packet's first beat with no idle cycle (or DONE if last packet).
REQ-021 GAP SHALL last exactly pkt_gap cycles with tvalid=0, then PKT or DONE.
REQ-022 tid SHALL be 0 for first packet of a run, increment per completed packet, wrap at 2^ID_W; tdest = latched pkt_dest.
REQ-023 pkt_sent SHALL clear in LOAD and increment on each final accepted beat; stays valid after run until next LOAD.
REQ-024 stream_abort (level, sampled each cycle) SHALL take effect only at packet boundaries: current packet completes normally, then DONE; abort in GAP SHALL go to DONE next cycle; abort in IDLE ignored.
REQ-025 DONE (one cycle) SHALL pulse stream_done, then IDLE.
REQ-026 stream_busy SHALL be 1 in all states except IDLE.

Reset
REQ-027 rst SHALL asynchronously force IDLE, tvalid=0, tlast=0, tkeep=0, tdata=0, tid=0, tdest=0, pkt_sent=0, stream_done=0, stream_busy=0, LFSR=1.
REQ-028 rst mid-packet SHALL drop tvalid immediately; no partial packet completion after release.

Structure
REQ-029 Package axis_pattern_gen_pkg SHALL hold state encodings, mode encodings and LFSR polynomial constant.
REQ-030 LFSR step SHALL be a separate sub-module lfsr32_step (combinational next-state, no storage).

Verification
REQ-031 TBYTE_NUM=16, mode1, start_from=0, inc=1, pkt_bytes=40, pkt_num=2, gap=3, tready=1 -> 3 beats/pkt data 0,1,2; last tkeep=16'h00FF; 3 idle cycles; tid 0 then 1; done pulse; pkt_sent=2.
REQ-032 Same, tready toggling 1/0 each cycle -> outputs stable while stalled, identical beat sequence, 6 beats total.
REQ-033 pkt_gap=0, pkt_num=3, pkt_bytes=16 -> 3 consecutive beats all tlast=1, tkeep=all-ones, no gap cycle.
REQ-034 mode2, seed 0 -> first beat lanes =1, subsequent beats match reference LFSR model across packet boundary.
REQ-035 stream_abort asserted at beat 1 of packet 0 (pkt_num=5) -> packet 0 completes, done pulses, pkt_sent=1; pkt_num=0 -> done 2 cycles after start, no tvalid.
REQ-036 rst asserted mid-packet -> tvalid low same cycle, busy=0, new start afterwards begins with tid=0.

Source files
------------

// File: rtl/axis_pattern_gen_pkg.sv
// Shared definitions for the AXI-Stream pattern generator.
//   state_t    : FSM state encoding (also visible on the debug state output)
//   mode_t     : payload pattern selection
//   LFSR_POLY  : Galois tap mask for x^32 + x^22 + x^2 + x + 1
//   lfsr_seed  : maps a seed to a legal (non-zero) LFSR state
package axis_pattern_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PKT  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Encoding 3 is not a distinct pattern; it produces the fixed pattern.
  typedef enum logic [1:0] {
    MODE_FIXED     = 2'd0,
    MODE_INC       = 2'd1,
    MODE_LFSR      = 2'd2,
    MODE_FIXED_ALT = 2'd3
  } mode_t;

  // Right-shifting Galois form: bits 31, 21, 1, 0 carry the x^32, x^22,
  // x^2 and x^1 terms.
  localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
  localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  function automatic logic [31:0] lfsr_seed(input logic [31:0] seed);
    return (seed == 32'h0) ? LFSR_RESET : seed;
  endfunction

endpackage

// File: rtl/lfsr32_step.sv
// One step of the 32-bit Galois LFSR. Purely combinational, no storage.
//   i_state : current LFSR state
//   o_next  : state after one shift
module lfsr32_step
  import axis_pattern_gen_pkg::*;
(
  input  logic [31:0] i_state,
  output logic [31:0] o_next
);

  always_comb begin
    o_next = {1'b0, i_state[31:1]};
    if (i_state[0]) begin
      o_next = o_next ^ LFSR_POLY;
    end
  end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI-Stream pattern generator. On stream_start it latches a run
// configuration and emits pkt_num packets of pkt_bytes bytes each, with
// pkt_gap idle cycles between packets, carrying a fixed, incrementing or
// LFSR payload.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   pkt_dest/gap/num/bytes   : run configuration (latched in LOAD)
//   mode, start_from, inc    : payload pattern, seed and step
//   stream_start/abort       : run control (abort acts at packet boundary)
//   stream_busy/done         : busy level, one-cycle completion pulse
//   pkt_sent                 : packets completed in the current/last run
//   m_axis_*                 : AXI-Stream master
//   o_dbg_state              : current FSM state (state_t encoding)
//
// Handshake: a beat transfers on a rising edge where tvalid & tready are
// both high. tvalid is raised only in PKT and, once raised, stays high with
// tdata/tkeep/tlast/tid/tdest unchanged until that transfer happens.
module axis_pattern_gen
  import axis_pattern_gen_pkg::*;
#(
  parameter int TBYTE_NUM = 16,
  parameter int ID_W      = 5,
  parameter int DEST_W    = 5,
  parameter int CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEST_W-1:0]      pkt_dest,
  input  logic [CNT_W-1:0]       pkt_gap,
  input  logic [CNT_W-1:0]       pkt_num,
  input  logic [CNT_W-1:0]       pkt_bytes,
  input  logic [1:0]             mode,
  input  logic [TBYTE_NUM*8-1:0] start_from,
  input  logic [TBYTE_NUM*8-1:0] inc,
  input  logic                   stream_start,
  input  logic                   stream_abort,
  output logic                   stream_busy,
  output logic                   stream_done,
  output logic [CNT_W-1:0]       pkt_sent,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TBYTE_NUM*8-1:0] m_axis_tdata,
  output logic [TBYTE_NUM-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [ID_W-1:0]        m_axis_tid,
  output logic [DEST_W-1:0]      m_axis_tdest,
  output logic [2:0]             o_dbg_state
);

  localparam int DW    = TBYTE_NUM * 8;
  localparam int LANES = (DW + 31) / 32;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t               r_state;
  mode_t                r_mode;
  logic [DW-1:0]        r_start;
  logic [DW-1:0]        r_inc;
  logic [CNT_W-1:0]     r_gap;
  logic [CNT_W-1:0]     r_num;
  logic [CNT_W-1:0]     r_beats_m1;
  logic [TBYTE_NUM-1:0] r_last_keep;
  logic [DEST_W-1:0]    r_dest;
  logic [DW-1:0]        r_data;
  logic [31:0]          r_lfsr;
  logic [CNT_W-1:0]     r_beat;
  logic [CNT_W-1:0]     r_gap_cnt;
  logic [CNT_W-1:0]     r_pkt_sent;
  logic [ID_W-1:0]      r_tid;
  logic                 r_abort_pend;

  // ---------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------
  state_t               w_state_nxt;
  logic                 w_tvalid;
  logic                 w_accept;
  logic                 w_last_beat;
  logic                 w_last_pkt;
  logic                 w_pkt_done;
  logic                 w_abort;
  logic [31:0]          w_lfsr_next;
  logic [31:0]          w_seed_src;
  logic [LANES*32-1:0]  w_lfsr_rep;
  logic [DW-1:0]        w_lfsr_lanes;
  logic [CNT_W-1:0]     w_load_quot;
  logic [CNT_W-1:0]     w_load_rem;
  logic [CNT_W-1:0]     w_load_beats_m1;
  logic [TBYTE_NUM-1:0] w_load_keep;

  // ---------------------------------------------------------------------
  // LFSR step and lane replication
  // ---------------------------------------------------------------------
  lfsr32_step u_lfsr_step (
    .i_state (r_lfsr),
    .o_next  (w_lfsr_next)
  );

  assign w_lfsr_rep   = {LANES{r_lfsr}};
  assign w_lfsr_lanes = w_lfsr_rep[DW-1:0];

  // Narrow beats (fewer than 32 bits) seed from a zero-extended start_from.
  generate
    if (DW >= 32) begin : g_seed_wide
      assign w_seed_src = start_from[31:0];
    end else begin : g_seed_narrow
      assign w_seed_src = {{(32-DW){1'b0}}, start_from};
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Packet geometry, computed from the live inputs during LOAD
  // ---------------------------------------------------------------------
  always_comb begin
    w_load_quot = pkt_bytes / CNT_W'(TBYTE_NUM);
    w_load_rem  = pkt_bytes % CNT_W'(TBYTE_NUM);
    // ceil(bytes/TBYTE_NUM) - 1; meaningless when pkt_bytes is zero, but
    // that case never reaches PKT.
    w_load_beats_m1 = (w_load_rem == '0) ? (w_load_quot - CNT_W'(1)) : w_load_quot;
    w_load_keep = '0;
    for (int i = 0; i < TBYTE_NUM; i++) begin
      w_load_keep[i] = (w_load_rem == '0) || (CNT_W'(i) < w_load_rem);
    end
  end

  // ---------------------------------------------------------------------
  // Handshake and boundary decode
  // ---------------------------------------------------------------------
  assign w_tvalid    = (r_state == ST_PKT);
  assign w_accept    = w_tvalid & m_axis_tready;
  assign w_last_beat = (r_beat == r_beats_m1);
  assign w_pkt_done  = w_accept & w_last_beat;
  assign w_last_pkt  = (r_pkt_sent == (r_num - CNT_W'(1)));
  // Abort is remembered once seen so a short pulse mid-packet still ends
  // the run at the next packet boundary.
  assign w_abort     = stream_abort | r_abort_pend;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stream_busy = 1'b1;
    stream_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stream_busy = 1'b0;
        if (stream_start) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if ((pkt_num == '0) || (pkt_bytes == '0)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_PKT;
        end
      end
      ST_PKT: begin
        if (w_pkt_done) begin
          if (w_last_pkt || w_abort) begin
            w_state_nxt = ST_DONE;
          end else if (r_gap != '0) begin
            w_state_nxt = ST_GAP;
          end else begin
            w_state_nxt = ST_PKT;
          end
        end
      end
      ST_GAP: begin
        if (w_abort) begin
          w_state_nxt = ST_DONE;
        end else if (r_gap_cnt == '0) begin
          w_state_nxt = ST_PKT;
        end
      end
      ST_DONE: begin
        stream_done = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode       <= MODE_FIXED;
      r_start      <= '0;
      r_inc        <= '0;
      r_gap        <= '0;
      r_num        <= '0;
      r_beats_m1   <= '0;
      r_last_keep  <= '0;
      r_dest       <= '0;
      r_data       <= '0;
      r_lfsr       <= LFSR_RESET;
      r_beat       <= '0;
      r_gap_cnt    <= '0;
      r_pkt_sent   <= '0;
      r_tid        <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_mode       <= mode_t'(mode);
          r_start      <= start_from;
          r_inc        <= inc;
          r_gap        <= pkt_gap;
          r_num        <= pkt_num;
          r_beats_m1   <= w_load_beats_m1;
          r_last_keep  <= w_load_keep;
          r_dest       <= pkt_dest;
          r_data       <= start_from;
          r_lfsr       <= lfsr_seed(w_seed_src);
          r_beat       <= '0;
          r_gap_cnt    <= '0;
          r_pkt_sent   <= '0;
          r_tid        <= '0;
          r_abort_pend <= 1'b0;
        end
        ST_PKT: begin
          if (stream_abort) begin
            r_abort_pend <= 1'b1;
          end
          if (w_accept) begin
            // The LFSR runs continuously across packets within a run.
            if (r_mode == MODE_LFSR) begin
              r_lfsr <= w_lfsr_next;
            end
            if (w_last_beat) begin
              r_beat     <= '0;
              r_data     <= r_start;
              r_pkt_sent <= r_pkt_sent + CNT_W'(1);
              r_tid      <= r_tid + ID_W'(1);
              // GAP exits when the counter reads zero, giving pkt_gap cycles.
              r_gap_cnt  <= r_gap - CNT_W'(1);
            end else begin
              r_beat <= r_beat + CNT_W'(1);
              if (r_mode == MODE_INC) begin
                r_data <= r_data + r_inc;
              end
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: payload qualifiers read zero whenever tvalid is low
  // ---------------------------------------------------------------------
  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tdata  = w_tvalid ? ((r_mode == MODE_LFSR) ? w_lfsr_lanes : r_data) : '0;
  assign m_axis_tkeep  = w_tvalid ? (w_last_beat ? r_last_keep : '1) : '0;
  assign m_axis_tlast  = w_tvalid & w_last_beat;
  assign m_axis_tid    = r_tid;
  assign m_axis_tdest  = r_dest;
  assign pkt_sent      = r_pkt_sent;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_axis_pattern_gen.sv
module tb_axis_pattern_gen;

  localparam int TB    = 16;
  localparam int DW    = TB * 8;
  localparam int ID_W  = 5;
  localparam int DST_W = 5;
  localparam int CNT_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DST_W-1:0] pkt_dest;
  logic [CNT_W-1:0] pkt_gap, pkt_num, pkt_bytes;
  logic [1:0]       mode;
  logic [DW-1:0]    start_from, inc;
  logic             stream_start, stream_abort;
  logic             stream_busy, stream_done;
  logic [CNT_W-1:0] pkt_sent;
  logic             m_axis_tvalid, m_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic [TB-1:0]    m_axis_tkeep;
  logic             m_axis_tlast;
  logic [ID_W-1:0]  m_axis_tid;
  logic [DST_W-1:0] m_axis_tdest;
  logic [2:0]       dbg_state;

  axis_pattern_gen #(
    .TBYTE_NUM (TB),
    .ID_W      (ID_W),
    .DEST_W    (DST_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_dest      (pkt_dest),
    .pkt_gap       (pkt_gap),
    .pkt_num       (pkt_num),
    .pkt_bytes     (pkt_bytes),
    .mode          (mode),
    .start_from    (start_from),
    .inc           (inc),
    .stream_start  (stream_start),
    .stream_abort  (stream_abort),
    .stream_busy   (stream_busy),
    .stream_done   (stream_done),
    .pkt_sent      (pkt_sent),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tdest  (m_axis_tdest),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [150:0] exp_q[$];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] m, input logic [DW-1:0] sf, input logic [DW-1:0] st,
                     input int bytes, input int num, input int gap, input logic [DST_W-1:0] dst);
    mode       = m;
    start_from = sf;
    inc        = st;
    pkt_bytes  = CNT_W'(bytes);
    pkt_num    = CNT_W'(num);
    pkt_gap    = CNT_W'(gap);
    pkt_dest   = dst;
  endtask

  // Checks one beat presented this cycle (tready held high by the caller).
  task automatic beat(input string tag, input logic [DW-1:0] d, input logic [TB-1:0] k,
                      input logic l, input logic [ID_W-1:0] id);
    chk({tag, "_valid"}, m_axis_tvalid, 1'b1);
    chk({tag, "_data"},  m_axis_tdata,  d);
    chk({tag, "_keep"},  m_axis_tkeep,  k);
    chk({tag, "_last"},  m_axis_tlast,  l);
    chk({tag, "_tid"},   m_axis_tid,    id);
  endtask

  function automatic logic [150:0] pack(input logic v, input logic [DW-1:0] d,
                                        input logic [TB-1:0] k, input logic l,
                                        input logic [ID_W-1:0] id);
    return {v, d, k, l, id};
  endfunction

  // ---------------- directed sequence ----------------
  logic [150:0] hold;
  logic [150:0] cur;
  logic [150:0] e;
  logic         have_hold;
  logic         done_seen;
  int           nbeats;
  logic [31:0]  lf [4];

  initial begin
    stream_start  = 1'b0;
    stream_abort  = 1'b0;
    m_axis_tready = 1'b1;
    cfg(2'd0, '0, '0, 0, 0, 0, '0);

    // ---- reset state ----
    step(); step();
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_busy",   stream_busy,   1'b0);
    chk("rst_done",   stream_done,   1'b0);
    chk("rst_tdata",  m_axis_tdata,  '0);
    chk("rst_tkeep",  m_axis_tkeep,  '0);
    chk("rst_tlast",  m_axis_tlast,  1'b0);
    chk("rst_tid",    m_axis_tid,    '0);
    chk("rst_tdest",  m_axis_tdest,  '0);
    chk("rst_sent",   pkt_sent,      '0);
    rst = 1'b0;
    step();

    // ---- run 1: mode1, 40 bytes, 2 packets, gap 3 ----
    cfg(2'd1, '0, 128'd1, 40, 2, 3, 5'd9);
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    chk("r1_load_valid", m_axis_tvalid, 1'b0);
    chk("r1_load_busy",  stream_busy,   1'b1);
    step();
    beat("r1_p0b0", 128'd0, 16'hFFFF, 1'b0, 5'd0);
    chk("r1_tdest", m_axis_tdest, 5'd9);
    // Config changes and a stray start during the run must have no effect.
    cfg(2'd0, 128'hDEAD, 128'd7, 16, 9, 0, 5'd3);
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    beat("r1_p0b1", 128'd1, 16'hFFFF, 1'b0, 5'd0);
    step();
    beat("r1_p0b2", 128'd2, 16'h00FF, 1'b1, 5'd0);
    step();
    chk("r1_gap1_valid", m_axis_tvalid, 1'b0);
    chk("r1_gap1_sent",  pkt_sent, 32'd1);
    step();
    chk("r1_gap2_valid", m_axis_tvalid, 1'b0);
    step();
    chk("r1_gap3_valid", m_axis_tvalid, 1'b0);
    step();
    beat("r1_p1b0", 128'd0, 16'hFFFF, 1'b0, 5'd1);
    chk("r1_p1_tdest", m_axis_tdest, 5'd9);
    step();
    beat("r1_p1b1", 128'd1, 16'hFFFF, 1'b0, 5'd1);
    step();
    beat("r1_p1b2", 128'd2, 16'h00FF, 1'b1, 5'd1);
    step();
    chk("r1_done_pulse", stream_done,   1'b1);
    chk("r1_done_valid", m_axis_tvalid, 1'b0);
    chk("r1_done_sent",  pkt_sent,      32'd2);
    step();
    chk("r1_idle_done", stream_done, 1'b0);
    chk("r1_idle_busy", stream_busy, 1'b0);
    chk("r1_idle_sent", pkt_sent,    32'd2);

    // ---- run 2: same run with tready toggling ----
    exp_q.delete();
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(pack(1'b1, 128'd0, 16'hFFFF, 1'b0, ID_W'(p)));
      exp_q.push_back(pack(1'b1, 128'd1, 16'hFFFF, 1'b0, ID_W'(p)));
      exp_q.push_back(pack(1'b1, 128'd2, 16'h00FF, 1'b1, ID_W'(p)));
    end
    cfg(2'd1, '0, 128'd1, 40, 2, 3, 5'd9);
    m_axis_tready = 1'b0;
    stream_start  = 1'b1;
    step();
    stream_start = 1'b0;
    have_hold = 1'b0;
    done_seen = 1'b0;
    nbeats    = 0;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      step();
      cur = pack(m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid);
      if (stream_done) done_seen = 1'b1;
      if (have_hold) begin
        chk("r2_stall_hold", cur, hold);
        have_hold = 1'b0;
      end
      m_axis_tready = c[0];
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          chk("r2_beat", cur, e);
          nbeats++;
        end else begin
          hold      = cur;
          have_hold = 1'b1;
        end
      end
    end
    m_axis_tready = 1'b1;
    chk("r2_done_seen", done_seen, 1'b1);
    chk("r2_beat_count", nbeats, 6);
    chk("r2_sent", pkt_sent, 32'd2);
    step();

    // ---- run 3: gap 0, 3 single-beat packets ----
    cfg(2'd0, 128'hA5A5_0F0F_1234_5678_9ABC_DEF0_0011_2233, '0, 16, 3, 0, 5'd1);
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      step();
      beat("r3_beat", 128'hA5A5_0F0F_1234_5678_9ABC_DEF0_0011_2233, 16'hFFFF, 1'b1, ID_W'(p));
    end
    step();
    chk("r3_done", stream_done, 1'b1);
    chk("r3_sent", pkt_sent, 32'd3);
    step();

    // ---- run 3b: mode 3 behaves as fixed even with non-zero inc ----
    cfg(2'd3, 128'h1234, 128'd5, 32, 1, 0, 5'd0);
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    step();
    beat("r3b_b0", 128'h1234, 16'hFFFF, 1'b0, 5'd0);
    step();
    beat("r3b_b1", 128'h1234, 16'hFFFF, 1'b1, 5'd0);
    step();
    chk("r3b_done", stream_done, 1'b1);
    step();

    // ---- run 4: LFSR, zero seed, 2 packets of 2 beats ----
    lf[0] = 32'h0000_0001;
    lf[1] = 32'h8020_0003;
    lf[2] = 32'hC030_0002;
    lf[3] = 32'h6018_0001;
    cfg(2'd2, '0, '0, 32, 2, 0, 5'd0);
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      step();
      beat("r4_lfsr", {4{lf[b]}}, 16'hFFFF, b[0], ID_W'(b / 2));
    end
    step();
    chk("r4_done", stream_done, 1'b1);
    step();

    // ---- run 5: abort during packet 0 of 5 ----
    cfg(2'd1, '0, 128'd1, 40, 5, 3, 5'd0);
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    step();
    beat("r5_b0", 128'd0, 16'hFFFF, 1'b0, 5'd0);
    step();
    beat("r5_b1", 128'd1, 16'hFFFF, 1'b0, 5'd0);
    stream_abort = 1'b1;
    step();
    beat("r5_b2", 128'd2, 16'h00FF, 1'b1, 5'd0);
    step();
    chk("r5_done",  stream_done,   1'b1);
    chk("r5_valid", m_axis_tvalid, 1'b0);
    chk("r5_sent",  pkt_sent,      32'd1);
    step();
    // abort still high while idle: ignored
    step();
    chk("r5_idle_abort_busy", stream_busy, 1'b0);
    stream_abort = 1'b0;

    // ---- run 5b: abort during a gap ----
    cfg(2'd0, 128'h77, '0, 16, 5, 3, 5'd0);
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    step();
    beat("r5b_b0", 128'h77, 16'hFFFF, 1'b1, 5'd0);
    step();
    chk("r5b_gap_valid", m_axis_tvalid, 1'b0);
    stream_abort = 1'b1;
    step();
    chk("r5b_done", stream_done, 1'b1);
    chk("r5b_sent", pkt_sent,    32'd1);
    stream_abort = 1'b0;
    step();

    // ---- run 5c: zero packets ----
    cfg(2'd0, '0, '0, 40, 0, 0, 5'd0);
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    chk("r5c_load_valid", m_axis_tvalid, 1'b0);
    step();
    chk("r5c_done",  stream_done,   1'b1);
    chk("r5c_valid", m_axis_tvalid, 1'b0);
    chk("r5c_sent",  pkt_sent,      32'd0);
    step();

    // ---- run 6: reset mid-run during packet 1 ----
    cfg(2'd1, '0, 128'd1, 16, 3, 0, 5'd2);
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    step();
    beat("r6_p0", 128'd0, 16'hFFFF, 1'b1, 5'd0);
    step();
    beat("r6_p1", 128'd0, 16'hFFFF, 1'b1, 5'd1);
    rst = 1'b1;
    #1;
    chk("r6_rst_valid", m_axis_tvalid, 1'b0);
    chk("r6_rst_busy",  stream_busy,   1'b0);
    chk("r6_rst_tid",   m_axis_tid,    '0);
    chk("r6_rst_sent",  pkt_sent,      '0);
    step();
    rst = 1'b0;
    step();
    chk("r6_post_busy",  stream_busy,   1'b0);
    chk("r6_post_valid", m_axis_tvalid, 1'b0);
    stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    step();
    beat("r6_new_p0", 128'd0, 16'hFFFF, 1'b1, 5'd0);
    chk("r6_new_tdest", m_axis_tdest, 5'd2);
    step();
    step();
    step();
    chk("r6_new_done", stream_done, 1'b1);
    chk("r6_new_sent", pkt_sent,    32'd3);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
